mul_cmp_monitor: RTL
====================

# mul_cmp_monitor

Synthesizable, parametrised dual-unit compare monitor for the core's multiply paths. It tracks in-order issue and writeback streams from a reference unit (A, the pipelined MUL) and a candidate unit (B, the MULE extension). It pairs their results in order, checks that values and destination registers match, and measures per-operation latency. It also keeps saturating match/mismatch counters, maximum-latency records and sticky error flags, so the comparison runs in simulation and on FPGA without a testbench.

## Interface
Parameters:
- DATA_W, 32, result width
- DEPTH, 4, entries per pending-issue FIFO and per result FIFO (power of two, ≥2)
- CNT_W, 16, width of the cycle counter, latencies and statistics counters
- TIMEOUT, 2000, age in cycles at which an oldest pending issue is flagged (must be < 2^CNT_W)

Ports (clock and reset are **one clock; reset asynchronous, active-high**):
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- enable_i  in  1  monitor active; when low all inputs are ignored and state holds
- clear_i  in  1  synchronous clear of all FIFOs, counters and flags
- a_issue_i / b_issue_i  in  1  operation issued to unit A / B
- a_issue_rd_i / b_issue_rd_i  in  5  destination register of the issue
- a_wb_valid_i / b_wb_valid_i  in  1  unit writeback strobe
- a_wb_rd_i / b_wb_rd_i  in  5  writeback destination register
- a_wb_value_i / b_wb_value_i  in  DATA_W  writeback value
- cmp_valid_o  out  1  one-cycle strobe: a compare result is presented
- cmp_match_o  out  1  values and rd equal for this pair
- cmp_rd_o  out  5  rd of the A result
- cmp_a_lat_o / cmp_b_lat_o  out  CNT_W  latencies of the paired operations
- match_count_o / mismatch_count_o  out  CNT_W  saturating pair counters
- max_lat_a_o / max_lat_b_o  out  CNT_W  maximum latency seen per unit
- err_overflow_o / err_underflow_o / err_order_o / err_timeout_o  out  1  sticky error flags
- busy_o  out  1  any FIFO non-empty

## Operation
- Cycle counter `cyc` (CNT_W) increments each enabled cycle and wraps modulo 2^CNT_W.
- Issue FIFO per unit. An issue pushes {rd, cyc}.
- Writeback pops the head of that unit's issue FIFO and computes lat = cyc − head.cyc (mod 2^CNT_W). It pushes {rd, value, lat} into the unit's result FIFO.
- If the writeback rd ≠ head.rd, the entry is still popped and err_order sets.
- A writeback with an empty issue FIFO sets err_underflow and is discarded. There is no same-cycle bypass, so minimum latency is 1.
- A push to a full FIFO, issue or result, sets err_overflow and is dropped. A simultaneous pop and push on a full FIFO is legal and is not an overflow.
- Compare: when both result FIFOs are non-empty, pop both heads and register the outputs.
  - cmp_match = (valueA == valueB) && (rdA == rdB).
  - Increment match_count or mismatch_count; both saturate at all-ones.
  - Update max_lat_a and max_lat_b (unsigned compare).
  - At most one compare per cycle.
- Timeout: if the issue FIFO is non-empty and cyc − head.cyc ≥ TIMEOUT, err_timeout sets. This is checked per unit.
- clear_i has priority over all same-cycle events. It empties the FIFOs, zeroes the counters, flags and cyc, and drops cmp_valid.

## Timing
- Reset (async) and clear: every output is 0, all FIFOs are empty, and cyc = 0.
- Issue at cycle t, writeback at cycle t+L → lat = L.
- cmp_valid_o is asserted on the edge after the cycle in which both result FIFOs are non-empty. Since a writeback becomes visible one edge after the later of the two writebacks, cmp_valid_o rises 2 cycles after that later writeback.
- Counters and max-latency outputs update on the same edge as cmp_valid_o.
- Error flags rise on the edge following the offending event and hold until reset or clear.
- enable_i low: no push, pop, count or compare. Outputs hold, except cmp_valid_o, which is forced to 0.
- Reset asserted mid-operation aborts immediately; pending entries are lost.

## Test plan
- A issues rd=12 at t=10, writes back 63 at t=13. B issues rd=13 at t=10, writes back 63 at t=15. Required: cmp_valid at t=17, match=0 (rd differs), lat 3/5, mismatch_count=1.
- Repeat with both using rd=12, value 63 → match=1, match_count=1, max_lat_a=3, max_lat_b=5.
- Repeat with B value 62 → match=0, mismatch_count=1, no error flags.
- DEPTH=4: five A issues with no writebacks → err_overflow=1, busy_o=1. Then a B writeback with no B issue → err_underflow=1.
- CNT_W=16: issue at cyc=0xFFFE, writeback at cyc=0x0001 → lat=3.
  - With TIMEOUT=2000, a pending issue of age 2000 → err_timeout=1.
  - A later clear_i zeroes all outputs and flags.
- A writeback rd=7 against head rd=12 → err_order=1, the entry is popped, and the next pair still compares.

Source files
------------

// File: rtl/mul_cmp_monitor_if.sv
// Issue/writeback streams of both multiply units plus the compare and statistics outputs.
// Latency: none; this is a signal bundle only.
// Backpressure: none; the monitor observes the streams and never stalls either unit.
interface mul_cmp_monitor_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic              a_issue_i;
    logic [4:0]        a_issue_rd_i;
    logic              a_wb_valid_i;
    logic [4:0]        a_wb_rd_i;
    logic [DATA_W-1:0] a_wb_value_i;

    logic              b_issue_i;
    logic [4:0]        b_issue_rd_i;
    logic              b_wb_valid_i;
    logic [4:0]        b_wb_rd_i;
    logic [DATA_W-1:0] b_wb_value_i;

    logic              cmp_valid_o;
    logic              cmp_match_o;
    logic [4:0]        cmp_rd_o;
    logic [CNT_W-1:0]  cmp_a_lat_o;
    logic [CNT_W-1:0]  cmp_b_lat_o;
    logic [CNT_W-1:0]  match_count_o;
    logic [CNT_W-1:0]  mismatch_count_o;
    logic [CNT_W-1:0]  max_lat_a_o;
    logic [CNT_W-1:0]  max_lat_b_o;
    logic              err_overflow_o;
    logic              err_underflow_o;
    logic              err_order_o;
    logic              err_timeout_o;
    logic              busy_o;

    // Core side: drives the unit activity, observes the monitor results.
    modport master (
        output a_issue_i, a_issue_rd_i, a_wb_valid_i, a_wb_rd_i, a_wb_value_i,
        output b_issue_i, b_issue_rd_i, b_wb_valid_i, b_wb_rd_i, b_wb_value_i,
        input  cmp_valid_o, cmp_match_o, cmp_rd_o, cmp_a_lat_o, cmp_b_lat_o,
        input  match_count_o, mismatch_count_o, max_lat_a_o, max_lat_b_o,
        input  err_overflow_o, err_underflow_o, err_order_o, err_timeout_o, busy_o
    );

    // Monitor side.
    modport slave (
        input  a_issue_i, a_issue_rd_i, a_wb_valid_i, a_wb_rd_i, a_wb_value_i,
        input  b_issue_i, b_issue_rd_i, b_wb_valid_i, b_wb_rd_i, b_wb_value_i,
        output cmp_valid_o, cmp_match_o, cmp_rd_o, cmp_a_lat_o, cmp_b_lat_o,
        output match_count_o, mismatch_count_o, max_lat_a_o, max_lat_b_o,
        output err_overflow_o, err_underflow_o, err_order_o, err_timeout_o, busy_o
    );
endinterface

// File: rtl/mul_cmp_monitor.sv
// Pairs in-order results of the reference MUL (A) and the MULE candidate (B), compares them, tracks latency/stats.
// Latency: writeback lands in a result FIFO after 1 edge; compare outputs register 1 edge later (2 cycles total).
// Backpressure: none; full FIFOs drop the push and raise err_overflow, orphan writebacks raise err_underflow.
module mul_cmp_monitor #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 2000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic             clear_i,
    mul_cmp_monitor_if.slave mon
);
    localparam int AW   = $clog2(DEPTH);
    localparam int IQ_W = 5 + CNT_W;
    localparam int RQ_W = 5 + DATA_W + CNT_W;
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [AW:0]      PTR_ONE   = (AW + 1)'(1);

    // Unit 0 is A (reference), unit 1 is B (candidate).
    logic              issue    [2];
    logic [4:0]        issue_rd [2];
    logic              wb_valid [2];
    logic [4:0]        wb_rd    [2];
    logic [DATA_W-1:0] wb_value [2];

    assign issue[0]    = mon.a_issue_i;
    assign issue[1]    = mon.b_issue_i;
    assign issue_rd[0] = mon.a_issue_rd_i;
    assign issue_rd[1] = mon.b_issue_rd_i;
    assign wb_valid[0] = mon.a_wb_valid_i;
    assign wb_valid[1] = mon.b_wb_valid_i;
    assign wb_rd[0]    = mon.a_wb_rd_i;
    assign wb_rd[1]    = mon.b_wb_rd_i;
    assign wb_value[0] = mon.a_wb_value_i;
    assign wb_value[1] = mon.b_wb_value_i;

    logic [CNT_W-1:0]  cyc;
    logic              active;
    logic              cmp_fire;
    logic              match_now;

    logic              iq_empty  [2];
    logic              iq_full   [2];
    logic              iq_pop    [2];
    logic              rq_empty  [2];
    logic              rq_full   [2];
    logic [4:0]        head_rd   [2];
    logic [CNT_W-1:0]  head_cyc  [2];
    logic [CNT_W-1:0]  age       [2];
    logic [4:0]        res_rd    [2];
    logic [DATA_W-1:0] res_value [2];
    logic [CNT_W-1:0]  res_lat   [2];
    logic              ovf_ev    [2];
    logic              unf_ev    [2];
    logic              ord_ev    [2];
    logic              tmo_ev    [2];

    logic              cmp_valid;
    logic              cmp_match;
    logic [4:0]        cmp_rd;
    logic [CNT_W-1:0]  cmp_a_lat;
    logic [CNT_W-1:0]  cmp_b_lat;
    logic [CNT_W-1:0]  match_count;
    logic [CNT_W-1:0]  mismatch_count;
    logic [CNT_W-1:0]  max_lat_a;
    logic [CNT_W-1:0]  max_lat_b;
    logic              err_overflow;
    logic              err_underflow;
    logic              err_order;
    logic              err_timeout;

    // Clear wins over everything, so it also suppresses every push/pop in its cycle.
    assign active    = enable_i && !clear_i;
    assign cmp_fire  = active && !rq_empty[0] && !rq_empty[1];
    assign match_now = (res_value[0] == res_value[1]) && (res_rd[0] == res_rd[1]);

    for (genvar u = 0; u < 2; u++) begin : g_unit
        logic [IQ_W-1:0] iq_mem [DEPTH];
        logic [RQ_W-1:0] rq_mem [DEPTH];
        logic [AW:0]     iq_wptr;
        logic [AW:0]     iq_rptr;
        logic [AW:0]     rq_wptr;
        logic [AW:0]     rq_rptr;
        logic            iq_do_push;
        logic            rq_do_push;

        // Pointers carry one wrap bit so full and empty are distinguishable.
        assign iq_empty[u] = (iq_wptr == iq_rptr);
        assign iq_full[u]  = (iq_wptr == {~iq_rptr[AW], iq_rptr[AW-1:0]});
        assign rq_empty[u] = (rq_wptr == rq_rptr);
        assign rq_full[u]  = (rq_wptr == {~rq_rptr[AW], rq_rptr[AW-1:0]});

        assign {head_rd[u], head_cyc[u]} = iq_mem[iq_rptr[AW-1:0]];
        assign {res_rd[u], res_value[u], res_lat[u]} = rq_mem[rq_rptr[AW-1:0]];

        // Modular difference: correct across a single cyc wrap.
        assign age[u] = cyc - head_cyc[u];

        // Only registered state is consulted, so a same-cycle issue cannot satisfy a writeback.
        assign iq_pop[u]  = active && wb_valid[u] && !iq_empty[u];
        assign iq_do_push = active && issue[u] && (!iq_full[u] || iq_pop[u]);
        assign rq_do_push = iq_pop[u] && (!rq_full[u] || cmp_fire);

        assign ovf_ev[u] = (active && issue[u] && iq_full[u] && !iq_pop[u]) ||
                           (iq_pop[u] && rq_full[u] && !cmp_fire);
        assign unf_ev[u] = active && wb_valid[u] && iq_empty[u];
        assign ord_ev[u] = iq_pop[u] && (wb_rd[u] != head_rd[u]);
        assign tmo_ev[u] = active && !iq_empty[u] && (age[u] >= TIMEOUT_C);

        // FIFO storage; contents need no reset since the pointers define validity.
        always_ff @(posedge clk_i) begin
            if (iq_do_push) iq_mem[iq_wptr[AW-1:0]] <= {issue_rd[u], cyc};
            if (rq_do_push) rq_mem[rq_wptr[AW-1:0]] <= {wb_rd[u], wb_value[u], age[u]};
        end

        // FIFO pointer advance; clear empties both queues of this unit.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                iq_wptr <= '0;
                iq_rptr <= '0;
                rq_wptr <= '0;
                rq_rptr <= '0;
            end else if (clear_i) begin
                iq_wptr <= '0;
                iq_rptr <= '0;
                rq_wptr <= '0;
                rq_rptr <= '0;
            end else begin
                if (iq_do_push) iq_wptr <= iq_wptr + PTR_ONE;
                if (iq_pop[u])  iq_rptr <= iq_rptr + PTR_ONE;
                if (rq_do_push) rq_wptr <= rq_wptr + PTR_ONE;
                if (cmp_fire)   rq_rptr <= rq_rptr + PTR_ONE;
            end
        end
    end

    // Free-running timestamp, frozen while disabled.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cyc <= '0;
        end else if (clear_i) begin
            cyc <= '0;
        end else if (enable_i) begin
            cyc <= cyc + CNT_ONE;
        end
    end

    // Registered compare result and saturating statistics, updated once per paired pop.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cmp_valid      <= 1'b0;
            cmp_match      <= 1'b0;
            cmp_rd         <= '0;
            cmp_a_lat      <= '0;
            cmp_b_lat      <= '0;
            match_count    <= '0;
            mismatch_count <= '0;
            max_lat_a      <= '0;
            max_lat_b      <= '0;
        end else if (clear_i) begin
            cmp_valid      <= 1'b0;
            cmp_match      <= 1'b0;
            cmp_rd         <= '0;
            cmp_a_lat      <= '0;
            cmp_b_lat      <= '0;
            match_count    <= '0;
            mismatch_count <= '0;
            max_lat_a      <= '0;
            max_lat_b      <= '0;
        end else begin
            cmp_valid <= cmp_fire;
            if (cmp_fire) begin
                cmp_match <= match_now;
                cmp_rd    <= res_rd[0];
                cmp_a_lat <= res_lat[0];
                cmp_b_lat <= res_lat[1];
                if (match_now) begin
                    if (match_count != '1) match_count <= match_count + CNT_ONE;
                end else begin
                    if (mismatch_count != '1) mismatch_count <= mismatch_count + CNT_ONE;
                end
                if (res_lat[0] > max_lat_a) max_lat_a <= res_lat[0];
                if (res_lat[1] > max_lat_b) max_lat_b <= res_lat[1];
            end
        end
    end

    // Sticky error flags; only reset or clear brings them back down.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
            err_order     <= 1'b0;
            err_timeout   <= 1'b0;
        end else if (clear_i) begin
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
            err_order     <= 1'b0;
            err_timeout   <= 1'b0;
        end else begin
            if (ovf_ev[0] || ovf_ev[1]) err_overflow  <= 1'b1;
            if (unf_ev[0] || unf_ev[1]) err_underflow <= 1'b1;
            if (ord_ev[0] || ord_ev[1]) err_order     <= 1'b1;
            if (tmo_ev[0] || tmo_ev[1]) err_timeout   <= 1'b1;
        end
    end

    assign mon.cmp_valid_o      = cmp_valid;
    assign mon.cmp_match_o      = cmp_match;
    assign mon.cmp_rd_o         = cmp_rd;
    assign mon.cmp_a_lat_o      = cmp_a_lat;
    assign mon.cmp_b_lat_o      = cmp_b_lat;
    assign mon.match_count_o    = match_count;
    assign mon.mismatch_count_o = mismatch_count;
    assign mon.max_lat_a_o      = max_lat_a;
    assign mon.max_lat_b_o      = max_lat_b;
    assign mon.err_overflow_o   = err_overflow;
    assign mon.err_underflow_o  = err_underflow;
    assign mon.err_order_o      = err_order;
    assign mon.err_timeout_o    = err_timeout;
    assign mon.busy_o           = !iq_empty[0] || !iq_empty[1] || !rq_empty[0] || !rq_empty[1];
endmodule
